// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: controller state
// encodings and the default geometry also used by decode/hazard logic.
package reg_file_mp_pkg;

  typedef enum logic {
    RF_ST_IDLE  = 1'b0,
    RF_ST_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DWIDTH = 32;
  localparam int RF_DEPTH  = 32;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: after rst it walks every entry index once,
// issuing a zero-write strobe per cycle, then parks in IDLE. The current
// state is exported so the top can derive busy and checkers can bind to it.
module rf_clear_seq
  import reg_file_mp_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int AWIDTH = $clog2(RF_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output rf_state_e         o_state,
  output logic              o_clr_we,
  output logic [AWIDTH-1:0] o_clr_addr
);

  rf_state_e         r_state;
  logic [AWIDTH-1:0] r_clr_idx;

  // State and index: any rst edge restarts the clear at entry 0; the index
  // stops at DEPTH-1 and the state drops to IDLE on that same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RF_ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        RF_ST_CLEAR: begin
          if (r_clr_idx == AWIDTH'(DEPTH - 1)) begin
            r_state <= RF_ST_IDLE;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: r_state <= RF_ST_IDLE;
      endcase
    end
  end

  // The zero-write is held off while rst is asserted so that the first
  // clear write always lands on entry 0 after release.
  assign o_state    = r_state;
  assign o_clr_we   = (r_state == RF_ST_CLEAR) && !i_rst;
  assign o_clr_addr = r_clr_idx;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two synchronous
// write ports (port 1 wins on an address collision), optional hardwired-zero
// entry 0, and a post-reset clear sequence during which busy=1, writes are
// ignored and every read returns 0.
// Optional feature macro: RF_BYPASS_EN -- when defined, a read of an address
// being written this cycle returns the incoming write data combinationally.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int  DWIDTH   = RF_DWIDTH,
  parameter int  DEPTH    = RF_DEPTH,
  parameter int  NUM_RD   = 2,
  parameter int  ZERO_REG = 1,
  localparam int AWIDTH   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [AWIDTH-1:0]        wa0,
  input  logic [DWIDTH-1:0]        wd0,
  input  logic                     we1,
  input  logic [AWIDTH-1:0]        wa1,
  input  logic [DWIDTH-1:0]        wd1,
  input  logic [NUM_RD*AWIDTH-1:0] ra,
  output logic [NUM_RD*DWIDTH-1:0] rd,
  output logic                     busy
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  rf_state_e         w_state;
  logic              w_clr_we;
  logic [AWIDTH-1:0] w_clr_addr;
  logic              w_busy;
  logic              w_wr_ok;
  logic              w_we0_eff;
  logic              w_we1_eff;

  rf_clear_seq #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_clear_seq (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_state    (w_state),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_busy  = (w_state == RF_ST_CLEAR);
  assign busy    = w_busy;
  assign w_wr_ok = !w_busy && !rst;

  // Effective write enables: suppressed while clearing, for entry 0 when it
  // is hardwired, and for port 0 when port 1 targets the same address.
  assign w_we1_eff = we1 && w_wr_ok && !(ZR && (wa1 == '0));
  assign w_we0_eff = we0 && w_wr_ok && !(ZR && (wa0 == '0)) &&
                     !(w_we1_eff && (wa0 == wa1));

  // Array update: the clear sequencer owns the array while busy.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_we0_eff) r_mem[wa0] <= wd0;
      if (w_we1_eff) r_mem[wa1] <= wd1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AWIDTH-1:0] w_ra;
    logic [DWIDTH-1:0] w_rdata;

    assign w_ra = ra[i*AWIDTH +: AWIDTH];

    // Read mux for one port: busy and hardwired zero force 0, otherwise the
    // stored value (or in-flight write data when bypass is built in).
    always_comb begin
      w_rdata = r_mem[w_ra];
`ifdef RF_BYPASS_EN
      if (w_we1_eff && (wa1 == w_ra)) begin
        w_rdata = wd1;
      end else if (w_we0_eff && (wa0 == w_ra)) begin
        w_rdata = wd0;
      end
`endif
      if (w_busy || (ZR && (w_ra == '0))) begin
        w_rdata = '0;
      end
    end

    assign rd[i*DWIDTH +: DWIDTH] = w_rdata;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Two instances share all inputs: one with
// the hardwired-zero entry (default) and one with ZERO_REG=0.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int DP = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk;
  logic             rst;
  logic             we0, we1;
  logic [AW-1:0]    wa0, wa1;
  logic [DW-1:0]    wd0, wd1;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd, rd_nz;
  logic             busy, busy_nz;

  int n_tests;
  int n_fail;

  reg_file_mp #(.DWIDTH(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .busy(busy)
  );

  reg_file_mp #(.DWIDTH(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_nz), .busy(busy_nz)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  task automatic idle_writes();
    we0 = 1'b0; we1 = 1'b0;
  endtask

  // Counts negedges with busy=1 (bounded); on the first non-busy sample the
  // write enables are dropped before the next rising edge.
  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    idle_writes();
    check(tag, DW'(cnt), DW'(DP));
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    idle_writes();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    ra  = '0;

    // Reset: two cycles of rst, then exactly DP busy cycles.
    tick();
    tick();
    check("busy_in_reset", DW'(busy), 32'd1);
    check("rd_in_reset", rd[DW-1:0], 32'd0);
    rst = 1'b0;
    count_busy("busy_len_reset");
    check("busy_after_clear", DW'(busy), 32'd0);

    for (int a = 0; a < DP; a++) begin
      set_ra(AW'(a), AW'(a));
      #1;
      check($sformatf("clr_rd0_e%0d", a), rd[DW-1:0], 32'd0);
      check($sformatf("clr_nz_e%0d", a), rd_nz[2*DW-1:DW], 32'd0);
    end

    // Basic write/read through both ports.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'd123;
    tick();
    idle_writes();
    set_ra(5'd0, 5'd7);
    @(negedge clk);
    check("basic_rd0", rd[DW-1:0], 32'd0);
    check("basic_rd1", rd[2*DW-1:DW], 32'd123);
    set_ra(5'd7, 5'd0);
    #1;
    check("swap_rd0", rd[DW-1:0], 32'd123);
    check("swap_rd1", rd[2*DW-1:DW], 32'd0);

    // Priority: port 1 wins on the same address.
    tick();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_AAAA;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h0000_5555;
    tick();
    idle_writes();
    set_ra(5'd5, 5'd5);
    @(negedge clk);
    check("prio_rd0", rd[DW-1:0], 32'h0000_5555);
    check("prio_rd1", rd[2*DW-1:DW], 32'h0000_5555);

    // Independent writes on both ports, top entry boundary.
    tick();
    we0 = 1'b1; wa0 = 5'd30; wd0 = 32'h1234_5678;
    we1 = 1'b1; wa1 = 5'd31; wd1 = 32'hCAFE_F00D;
    tick();
    idle_writes();
    set_ra(5'd30, 5'd31);
    @(negedge clk);
    check("dual_wr_e30", rd[DW-1:0], 32'h1234_5678);
    check("dual_wr_e31", rd[2*DW-1:DW], 32'hCAFE_F00D);

    // Hardwired zero entry vs ordinary entry 0.
    tick();
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hDEAD_BEEF;
    tick();
    idle_writes();
    set_ra(5'd0, 5'd0);
    @(negedge clk);
    check("zero_reg_on", rd[DW-1:0], 32'd0);
    check("zero_reg_off", rd_nz[DW-1:0], 32'hDEAD_BEEF);

    // Same-cycle read of an entry being written.
    tick();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'd42;
    set_ra(5'd3, 5'd3);
    @(negedge clk);
`ifdef RF_BYPASS_EN
    check("bypass_same_cycle", rd[DW-1:0], 32'd42);
`else
    check("bypass_same_cycle", rd[DW-1:0], 32'd0);
`endif
    tick();
    idle_writes();
    @(negedge clk);
    check("bypass_next_cycle", rd[DW-1:0], 32'd42);

    // Clear abort: restart the clear mid-sequence while writes are attempted.
    tick();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'd77;
    tick();
    idle_writes();
    set_ra(5'd9, 5'd12);
    @(negedge clk);
    check("pre_abort_e9", rd[DW-1:0], 32'd77);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we0 = 1'b1; wa0 = 5'd9;  wd0 = 32'd55;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'd66;
    @(negedge clk);
    check("abort_busy_rd_zero", rd[DW-1:0], 32'd0);
    check("abort_busy_nz", rd_nz[2*DW-1:DW], 32'd0);
    tick();
    for (int k = 1; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("busy_len_abort");
    set_ra(5'd9, 5'd12);
    #1;
    check("abort_e9", rd[DW-1:0], 32'd0);
    check("abort_e12", rd[2*DW-1:DW], 32'd0);
    set_ra(5'd7, 5'd31);
    #1;
    check("abort_e7", rd[DW-1:0], 32'd0);
    check("abort_e31", rd[2*DW-1:DW], 32'd0);

    // Writes work again on the first IDLE cycles.
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'd88;
    tick();
    idle_writes();
    set_ra(5'd9, 5'd9);
    @(negedge clk);
    check("post_abort_wr", rd[2*DW-1:DW], 32'd88);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
